nes_clock_enable_gen: RTL

// - Sits directly downstream of the system PLL (50 MHz in, 21.477272 MHz NES master clock out).
// - Consumes the PLL's master clock and its locked output.
// - Issues the design-wide reset and the NTSC clock enables:
//   - CPU: master/12
//   - PPU: master/4
//   - APU: CPU/2
// - Every NES core block runs on the single master clock and advances only on these enables.

---
 rtl/nes_clk_pkg.sv | 19 +
 rtl/bit_sync.sv | 31 +++
 rtl/nes_clock_enable_gen.sv | 134 +++++++++++++
 3 files changed

// File: rtl/nes_clk_pkg.sv
// -----------------------------------------------------------------------------
// nes_clk_pkg
// Shared types and constants for the NES master-clock enable generator.
//   state_t      : reset/lock sequencing state (WAIT_LOCK, HOLD, RUN)
//   NES_CPU_DIV  : NTSC master cycles per CPU cycle
//   NES_PPU_DIV  : NTSC master cycles per PPU dot
// -----------------------------------------------------------------------------
package nes_clk_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2
   } state_t;

   localparam int NES_CPU_DIV = 12;
   localparam int NES_PPU_DIV = 4;

endpackage : nes_clk_pkg

// File: rtl/bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// Multi-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk : destination clock
//   rst : synchronous active-high reset, clears every stage
//   d   : asynchronous input level
//   q   : d delayed through STAGES flops
// -----------------------------------------------------------------------------
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule : bit_sync

// File: rtl/nes_clock_enable_gen.sv
// -----------------------------------------------------------------------------
// nes_clock_enable_gen
// Sits after the system PLL. Holds the NES core in reset until the PLL has been
// stably locked for LOCK_HOLD cycles, then issues the NTSC clock enables
// (CPU = master/CPU_DIV, PPU = master/PPU_DIV, APU = every second CPU enable).
// Ports:
//   clk        : master clock (PLL outclk_0)
//   rst        : synchronous active-high reset
//   pll_locked : PLL locked output, asynchronous to clk
//   halt       : debug freeze, gates all enables while running
//   sys_rst    : registered active-high reset to the NES core
//   cpu_ce     : one-cycle CPU clock-enable pulse
//   ppu_ce     : one-cycle PPU clock-enable pulse
//   apu_ce     : one-cycle APU clock-enable pulse
//   phase      : master phase within the CPU cycle (0..CPU_DIV-1)
//   lock_lost  : sticky flag, lock dropped after running; cleared by rst
//   fsm_state  : debug view of the sequencing state
// -----------------------------------------------------------------------------
module nes_clock_enable_gen
   import nes_clk_pkg::*;
#(
   parameter int CPU_DIV     = NES_CPU_DIV,
   parameter int PPU_DIV     = NES_PPU_DIV,
   parameter int LOCK_HOLD   = 1024,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       halt,
   output logic       sys_rst,
   output logic       cpu_ce,
   output logic       ppu_ce,
   output logic       apu_ce,
   output logic [3:0] phase,
   output logic       lock_lost,
   output state_t     fsm_state
);

   localparam int PW = $clog2(CPU_DIV);
   localparam int HW = $clog2(LOCK_HOLD + 1);

   localparam logic [PW-1:0] PHASE_LAST = PW'(CPU_DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(LOCK_HOLD - 1);
   localparam logic [31:0]   PPU_DIV_U  = 32'(PPU_DIV);

   state_t          state;
   logic [HW-1:0]   hold_cnt;
   logic [PW-1:0]   phase_q;
   logic            apu_tog;
   logic            lk_s;
   logic            run_go;

   bit_sync #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lk_s)
   );

   // Enables are decoded from registered state so they line up with phase and
   // drop in the same cycle halt is raised.
   assign run_go = (state == RUN) && !halt;
   assign cpu_ce = run_go && (phase_q == '0);
   assign ppu_ce = run_go && ((32'(phase_q) % PPU_DIV_U) == 32'd0);
   assign apu_ce = cpu_ce && !apu_tog;

   assign phase     = 4'(phase_q);
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= WAIT_LOCK;
         sys_rst   <= 1'b1;
         lock_lost <= 1'b0;
         hold_cnt  <= '0;
         phase_q   <= '0;
         apu_tog   <= 1'b0;
      end else begin
         case (state)
            WAIT_LOCK: begin
               sys_rst  <= 1'b1;
               hold_cnt <= '0;
               phase_q  <= '0;
               apu_tog  <= 1'b0;
               if (lk_s) begin
                  state <= HOLD;
               end
            end

            HOLD: begin
               phase_q <= '0;
               apu_tog <= 1'b0;
               // A drop on the terminal cycle must still abort, so lk_s is
               // tested before the terminal count.
               if (!lk_s) begin
                  state    <= WAIT_LOCK;
                  hold_cnt <= '0;
               end else if (hold_cnt == HOLD_LAST) begin
                  state    <= RUN;
                  sys_rst  <= 1'b0;
                  hold_cnt <= '0;
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end

            RUN: begin
               // Lock loss wins over halt.
               if (!lk_s) begin
                  state     <= WAIT_LOCK;
                  sys_rst   <= 1'b1;
                  lock_lost <= 1'b1;
                  phase_q   <= '0;
                  apu_tog   <= 1'b0;
               end else if (!halt) begin
                  phase_q <= (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
                  if (cpu_ce) begin
                     apu_tog <= ~apu_tog;
                  end
               end
            end

            default: begin
               state   <= WAIT_LOCK;
               sys_rst <= 1'b1;
            end
         endcase
      end
   end

endmodule : nes_clock_enable_gen
